// File: rtl/alu_ctrl_if.sv
// Instruction handshake and ALU operand/result bundle for alu_ctrl.
// master: instruction source plus external ALU; slave: the controller.
interface alu_ctrl_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_opcode;
    logic [7:0]  alu_result;
    logic        alu_carry;
    logic        alu_overflow;

    modport master (
        output instr, instr_valid, alu_result, alu_carry, alu_overflow,
        input  instr_ready, alu_a, alu_b, alu_opcode
    );

    modport slave (
        input  instr, instr_valid, alu_result, alu_carry, alu_overflow,
        output instr_ready, alu_a, alu_b, alu_opcode
    );
endinterface

// File: rtl/alu_ctrl.sv
// alu_ctrl: sequences one instruction through IDLE->DECODE->EXEC->WB against
// an external combinational ALU, with a 4x8 register file.
// Optional feature: define ALU_CTRL_FLAGS_EN to get registered Z/C/V flags;
// otherwise the flag outputs are constant 0.
module alu_ctrl (
    input  logic        clk,
    input  logic        rst,
    alu_ctrl_if.slave   bus,
    output logic        done,
    output logic        err,
    output logic        flag_z,
    output logic        flag_c,
    output logic        flag_v,
    input  logic [1:0]  dbg_sel,
    output logic [7:0]  dbg_data
);
    localparam int unsigned DW    = 8;
    localparam int unsigned OPW   = 4;
    localparam int unsigned NREG  = 4;
    localparam logic [OPW-1:0] OP_ADD = 4'b0000;
    localparam logic [OPW-1:0] OP_SUB = 4'b0001;
    localparam logic [OPW-1:0] OP_LDI = 4'b1000;

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    state_t          state;
    state_t          state_next;
    logic            accept;
    logic [15:0]     instr_q;
    logic            illegal_q;
    logic [DW-1:0]   result_q;
    logic [DW-1:0]   regs [NREG];

    logic [OPW-1:0]  op;
    logic [1:0]      rd;
    logic [1:0]      rs1;
    logic [1:0]      rs2;
    logic [DW-1:0]   imm;

    assign op  = instr_q[15:12];
    assign rd  = instr_q[11:10];
    assign rs1 = instr_q[9:8];
    assign rs2 = instr_q[7:6];
    assign imm = instr_q[7:0];

    assign dbg_data = regs[dbg_sel];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and accept strobe.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.instr_valid) begin
                    accept     = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE:  state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: instruction latch, operand issue, result capture, writeback, pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.instr_ready <= 1'b1;
            bus.alu_a       <= '0;
            bus.alu_b       <= '0;
            bus.alu_opcode  <= '0;
            instr_q         <= '0;
            illegal_q       <= 1'b0;
            result_q        <= '0;
            done            <= 1'b0;
            err             <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            bus.instr_ready <= (state_next == IDLE);
            done            <= (state_next == WB) && !illegal_q;
            err             <= (state_next == WB) && illegal_q;
            if (accept) instr_q <= bus.instr;
            if (state == DECODE) begin
                bus.alu_opcode <= op;
                bus.alu_a      <= regs[rs1];
                bus.alu_b      <= (op == OP_LDI) ? imm : regs[rs2];
                illegal_q      <= (op > OP_LDI);
            end
            if (state == EXEC) result_q <= bus.alu_result;
            if ((state == WB) && !illegal_q) regs[rd] <= result_q;
        end
    end

`ifdef ALU_CTRL_FLAGS_EN
    // Status flags, updated at writeback of legal instructions only.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else if ((state == WB) && !illegal_q) begin
            flag_z <= (result_q == '0);
            if ((bus.alu_opcode == OP_ADD) || (bus.alu_opcode == OP_SUB)) begin
                flag_c <= bus.alu_carry;
                flag_v <= bus.alu_overflow;
            end else begin
                flag_c <= 1'b0;
                flag_v <= 1'b0;
            end
        end
    end
`else
    logic unused_flag_inputs;
    assign unused_flag_inputs = bus.alu_carry ^ bus.alu_overflow;
    assign flag_z = 1'b0;
    assign flag_c = 1'b0;
    assign flag_v = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a transaction-level reference model.
module tb_alu_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       done, err, flag_z, flag_c, flag_v;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;

    alu_ctrl_if bus();

    alu_ctrl dut (
        .clk(clk), .rst(rst), .bus(bus),
        .done(done), .err(err),
        .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Environment ALU: {overflow, carry/borrow, result}.
    function automatic logic [9:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic       v;
        v = 1'b0;
        case (op)
            4'h0: begin s = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (s[7] != a[7]); end
            4'h1: begin s = {1'b0, a} - {1'b0, b}; v = (a[7] != b[7]) && (s[7] != a[7]); end
            4'h2: s = {1'b0, a & b};
            4'h3: s = {1'b0, a | b};
            4'h4: s = {1'b0, a ^ b};
            4'h8: s = {1'b0, b};
            default: s = {1'b0, a};
        endcase
        return {v, s};
    endfunction

    always_comb {bus.alu_overflow, bus.alu_carry, bus.alu_result} = alu_f(bus.alu_opcode, bus.alu_a, bus.alu_b);

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register file, flags, and one in-flight instruction tracked by age.
    logic [7:0]  rm [4];
    logic        mz, mc, mv;
    logic [7:0]  ma, mb;
    logic [3:0]  mop;
    logic [15:0] minstr;
    bit          pending = 0;
    bit          en = 0;
    int          cyc = 0;
    int          acc = 0;

    function automatic bit legal(input logic [15:0] i);
        return i[15:12] <= 4'h8;
    endfunction

    initial forever begin
        logic [9:0] r;
        @(posedge clk);
        cyc++;
        if (rst) begin
            for (int i = 0; i < 4; i++) rm[i] = 8'h00;
            {mz, mc, mv} = 3'b000;
            {ma, mb, mop} = 20'h0;
            pending = 0;
            en = 1;
        end else if (pending) begin
            if (cyc - acc == 1) begin
                mop = minstr[15:12];
                ma  = rm[minstr[9:8]];
                mb  = (mop == 4'h8) ? minstr[7:0] : rm[minstr[7:6]];
            end
            if (cyc - acc == 3) begin
                if (legal(minstr)) begin
                    r = alu_f(mop, ma, mb);
                    rm[minstr[11:10]] = r[7:0];
`ifdef ALU_CTRL_FLAGS_EN
                    mz = (r[7:0] == 8'h00);
                    mc = (mop <= 4'h1) ? r[8] : 1'b0;
                    mv = (mop <= 4'h1) ? r[9] : 1'b0;
`endif
                end
                pending = 0;
            end
        end else if (bus.instr_valid) begin
            minstr  = bus.instr;
            pending = 1;
            acc     = cyc;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    initial begin
        dbg_sel = 2'd0;
        forever begin
            @(negedge clk);
            if (en) begin
                chk("instr_ready", 8'(bus.instr_ready), 8'(!pending));
                chk("done", 8'(done), 8'(pending && (cyc - acc == 2) && legal(minstr)));
                chk("err", 8'(err), 8'(pending && (cyc - acc == 2) && !legal(minstr)));
                chk("flag_z", 8'(flag_z), 8'(mz));
                chk("flag_c", 8'(flag_c), 8'(mc));
                chk("flag_v", 8'(flag_v), 8'(mv));
                chk("alu_a", bus.alu_a, ma);
                chk("alu_b", bus.alu_b, mb);
                chk("alu_opcode", 8'(bus.alu_opcode), 8'(mop));
                for (int i = 0; i < 4; i++) begin
                    dbg_sel = 2'(i);
                    #1;
                    chk($sformatf("dbg_data[%0d]", i), dbg_data, rm[i]);
                end
            end
        end
    end

    // Issue one instruction on an idle DUT; return edges from accept to the done/err pulse.
    task automatic issue(input logic [15:0] ins, output int lat, output logic was_err);
        @(posedge clk); #2;
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        @(posedge clk); #2;
        bus.instr_valid = 1'b0;
        lat = 0;
        was_err = 1'bx;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (done || err) begin
                lat = k;
                was_err = err;
                break;
            end
        end
    endtask

    localparam logic [15:0] LDI_R1_C8 = {4'h8, 2'd1, 2'd0, 8'hC8};
    localparam logic [15:0] LDI_R2_64 = {4'h8, 2'd2, 2'd0, 8'h64};
    localparam logic [15:0] ADD_R3    = {4'h0, 2'd3, 2'd1, 2'd2, 6'd0};
    localparam logic [15:0] LDI_R1_55 = {4'h8, 2'd1, 2'd0, 8'h55};
    localparam logic [15:0] SUB_R0    = {4'h1, 2'd0, 2'd1, 2'd1, 6'd0};
    localparam logic [15:0] ILL_R2    = {4'hA, 2'd2, 2'd1, 2'd1, 6'd0};
    localparam logic [15:0] AND_R0    = {4'h2, 2'd0, 2'd1, 2'd2, 6'd0};

    initial begin
        int   lat;
        logic e;
        int   nready, ndone;
        rst = 1'b1;
        bus.instr = 16'h0;
        bus.instr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Load/load/add with carry out.
        issue(LDI_R1_C8, lat, e);
        chk("lat_ldi1", 8'(lat), 8'd3);
        issue(LDI_R2_64, lat, e);
        chk("lat_ldi2", 8'(lat), 8'd3);
        issue(ADD_R3, lat, e);
        chk("lat_add", 8'(lat), 8'd3);
        chk("add_is_done", 8'(e), 8'd0);
        @(negedge clk);
        chk("model_r3", rm[3], 8'h2C);
`ifdef ALU_CTRL_FLAGS_EN
        chk("model_c_add", 8'(mc), 8'd1);
        chk("model_z_add", 8'(mz), 8'd0);
`endif

        // Self-subtract gives zero, no borrow.
        issue(LDI_R1_55, lat, e);
        issue(SUB_R0, lat, e);
        chk("lat_sub", 8'(lat), 8'd3);
        @(negedge clk);
        chk("model_r0", rm[0], 8'h00);
`ifdef ALU_CTRL_FLAGS_EN
        chk("model_z_sub", 8'(mz), 8'd1);
        chk("model_c_sub", 8'(mc), 8'd0);
`endif

        // Illegal opcode: err instead of done, R2 untouched.
        issue(ILL_R2, lat, e);
        chk("lat_ill", 8'(lat), 8'd3);
        chk("ill_is_err", 8'(e), 8'd1);
        @(negedge clk);
        chk("model_r2_kept", rm[2], 8'h64);

        // Valid held high: one accept per four cycles.
        @(posedge clk); #2;
        bus.instr = AND_R0;
        bus.instr_valid = 1'b1;
        nready = 0;
        ndone = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (bus.instr_ready) nready++;
            if (done) ndone++;
        end
        #2 bus.instr_valid = 1'b0;
        chk("ready_1_in_4", 8'(nready), 8'd4);
        chk("done_1_in_4", 8'(ndone), 8'd4);
        repeat (6) @(posedge clk);

        // Reset during EXEC of ADD R3 aborts it.
        issue(LDI_R1_C8, lat, e);
        issue(ADD_R3, lat, e);
        @(posedge clk); #2;
        bus.instr = ADD_R3;
        bus.instr_valid = 1'b1;
        @(posedge clk); #2;
        bus.instr_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 8'(bus.instr_ready), 8'd1);
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("no_done_after_abort", 8'(ndone), 8'd0);
        chk("model_r3_cleared", rm[3], 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have port clk, input, 1; the single clock, and all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1; the reset, synchronous and active-high.
REQ-003 SHALL have port instr, input, 16; the instruction word: op[15:12], rd[11:10], rs1[9:8], rs2[7:6], imm[7:0].
REQ-004 SHALL have port instr_valid, input, 1; asserted when instr holds a valid instruction.
REQ-005 SHALL have port instr_ready, output, 1; asserted when the block can accept an instruction.
REQ-006 SHALL have port alu_a, output, 8; operand A driven to the ALU.
REQ-007 SHALL have port alu_b, output, 8; operand B driven to the ALU.
REQ-008 SHALL have port alu_opcode, output, 4; the opcode driven to the ALU.
REQ-009 SHALL have port alu_result, input, 8; the combinational result from the ALU.
REQ-010 SHALL have ports alu_carry and alu_overflow, input, 1 each; the ALU flags.
REQ-011 SHALL have port done, output, 1; a one-cycle pulse at writeback.
REQ-012 SHALL have port err, output, 1; a one-cycle pulse on an illegal opcode.
REQ-013 SHALL have ports flag_z, flag_c and flag_v, output, 1 each; the registered status flags.
REQ-014 SHALL have ports dbg_sel (input, 2) and dbg_data (output, 8); dbg_data is a combinational read of R[dbg_sel].

Function
REQ-015 SHALL hold a register file R0..R3, each 8 bits.
REQ-016 SHALL implement the FSM IDLE->DECODE->EXEC->WB->IDLE, with one cycle per state outside IDLE.
REQ-017 SHALL assert instr_ready only in IDLE; an instruction is accepted when instr_valid&instr_ready at a rising edge, and instr is latched internally.
REQ-018 SHALL, in DECODE, register alu_opcode=op and alu_a=R[rs1], with alu_b=imm when op=4'b1000 and alu_b=R[rs2] otherwise.
REQ-019 SHALL, in EXEC, hold the ALU inputs stable and capture alu_result into an internal result register.
REQ-020 SHALL, in WB, write the result to R[rd], pulse done=1, and return to IDLE.
REQ-021 SHALL, when op is in 4'b1001..4'b1111, detect it in DECODE, perform no writeback and no flag update, pulse err in WB instead of done, and R SHALL be unchanged.
REQ-022 SHALL pulse done at cycle N+3 for an instruction accepted at edge N, giving a peak throughput of 1 instruction per 4 cycles.
REQ-023 SHALL read operands before writeback when rd equals rs1 or rs2, so the old value is used.
REQ-024 SHALL ignore instr_valid outside IDLE, with no queuing.
REQ-025 SHALL hold alu_a, alu_b and alu_opcode at their last values while in IDLE.

Reset
REQ-026 SHALL, when rst=1 at any edge and in any state, force IDLE, clear R0..R3, alu_a, alu_b, alu_opcode and the result register to 0, and clear done, err, flag_z, flag_c and flag_v to 0.
REQ-027 SHALL abort an in-flight instruction on reset, with no writeback and no done pulse, and set instr_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-028 SHALL, when ALU_CTRL_FLAGS_EN is defined, update flags in WB of every legal instruction: flag_z=(result==0); flag_c=alu_carry and flag_v=alu_overflow for op 0000 or 0001, both cleared to 0 otherwise.
REQ-029 SHALL, when ALU_CTRL_FLAGS_EN is undefined, tie flag_z, flag_c and flag_v to constant 0, with no flag registers present.

Verification
REQ-030 SHALL cover: reset, then load imm R1=0xC8 (op 1000), then R2=0x64, then ADD R3=R1+R2 -> dbg_data(3)=0x2C, flag_c=1, flag_z=0, done pulses 3 cycles after each accept.
REQ-031 SHALL cover: SUB R0=R1-R1 with R1=0x55 -> R0=0x00, flag_z=1, flag_c=0.
REQ-032 SHALL cover: op 4'b1010 with rd=2 -> err pulses once at N+3, done stays 0, R2 and the flags unchanged.
REQ-033 SHALL cover: instr_valid held high continuously -> instr_ready high only 1 cycle in 4, exactly one instruction accepted per 4 cycles.
REQ-034 SHALL cover: rst asserted during EXEC of ADD R3 -> R3=0, no done, instr_ready=1 on the next cycle after rst is released.
